// File: rtl/i2c_target_mem.sv
// I2C target emulating an AT24C02-style byte-addressed memory.
// Supports a word-address pointer, sequential writes, and sequential or random
// reads with pointer auto-increment. Every committed write byte is also
// reported on the wr_valid/wr_addr/wr_data strobe.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | bus free, or after STOP; waiting for START
// DEV       | shifting in the device address + R/W byte
// DEV_ACK   | driving ACK for a matching device address
// WADDR     | shifting in the word address that loads ptr
// WADDR_ACK | driving ACK for the word address
// WDATA     | shifting in a write data byte
// WDATA_ACK | driving ACK for a committed write byte
// RDATA     | shifting out mem[ptr], MSB first
// RD_MACK   | released; sampling the master's ACK/NACK
// IGNORE    | not addressed or read finished; bus left alone
module i2c_target_mem #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         MEM_AW   = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_valid,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [MEM_AW-1:0] ptr
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK,
        WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE
    } state_t;

    localparam logic [MEM_AW-1:0] PTR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    logic [7:0] mem [2**MEM_AW];

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t            state, state_nx;
    logic [2:0]        bit_cnt, bit_cnt_nx;
    logic [7:0]        shreg, shreg_nx;
    logic [7:0]        rd_sh, rd_sh_nx;
    logic              got_byte, got_byte_nx;
    logic              rw_bit, rw_bit_nx;
    logic              sda_oe_nx, busy_nx, wr_valid_nx;
    logic [MEM_AW-1:0] wr_addr_nx, ptr_nx;
    logic [7:0]        wr_data_nx;
    logic              mem_we;
    logic [7:0]        rx_byte;
    logic [7:0]        mem_rd;

    // Synchronizers plus history flops; reset to the idle-high bus level so
    // leaving reset never looks like a START.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
        end else begin
            scl_s1 <= scl_i; scl_s2 <= scl_s1; scl_h <= scl_s2;
            sda_s1 <= sda_i; sda_s2 <= sda_s1; sda_h <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & ~sda_h & sda_s2;
    assign rx_byte   = {shreg[6:0], sda_s2};
    assign mem_rd    = mem[ptr];

    // Storage has no reset; a committed write lands at the current pointer.
    always_ff @(posedge aclk) begin
        if (mem_we) mem[ptr] <= rx_byte;
    end

    // State and output registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            rd_sh    <= 8'd0;
            got_byte <= 1'b0;
            rw_bit   <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
            ptr      <= '0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_cnt_nx;
            shreg    <= shreg_nx;
            rd_sh    <= rd_sh_nx;
            got_byte <= got_byte_nx;
            rw_bit   <= rw_bit_nx;
            sda_oe   <= sda_oe_nx;
            busy     <= busy_nx;
            wr_valid <= wr_valid_nx;
            wr_addr  <= wr_addr_nx;
            wr_data  <= wr_data_nx;
            ptr      <= ptr_nx;
        end
    end

    // Next-state and output decode. got_byte marks "8 bits taken on a rise,
    // act on the following fall" so SDA only ever moves while SCL is low.
    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        rd_sh_nx    = rd_sh;
        got_byte_nx = got_byte;
        rw_bit_nx   = rw_bit;
        sda_oe_nx   = sda_oe;
        busy_nx     = busy;
        wr_valid_nx = 1'b0;
        wr_addr_nx  = wr_addr;
        wr_data_nx  = wr_data;
        ptr_nx      = ptr;
        mem_we      = 1'b0;

        if (start_det) begin
            state_nx    = DEV;
            bit_cnt_nx  = 3'd0;
            got_byte_nx = 1'b0;
            sda_oe_nx   = 1'b0;
            busy_nx     = 1'b0;
        end else if (stop_det) begin
            state_nx    = IDLE;
            bit_cnt_nx  = 3'd0;
            got_byte_nx = 1'b0;
            sda_oe_nx   = 1'b0;
            busy_nx     = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                DEV: begin
                    if (scl_rise && !got_byte) begin
                        shreg_nx   = rx_byte;
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                got_byte_nx = 1'b1;
                                rw_bit_nx   = rx_byte[0];
                            end else begin
                                state_nx = IGNORE;
                            end
                        end
                    end else if (scl_fall && got_byte) begin
                        got_byte_nx = 1'b0;
                        sda_oe_nx   = 1'b1;
                        busy_nx     = 1'b1;
                        state_nx    = DEV_ACK;
                    end
                end
                DEV_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nx = 3'd0;
                        if (rw_bit) begin
                            rd_sh_nx  = mem_rd;
                            sda_oe_nx = ~mem_rd[7];
                            state_nx  = RDATA;
                        end else begin
                            sda_oe_nx = 1'b0;
                            state_nx  = WADDR;
                        end
                    end
                end
                WADDR: begin
                    if (scl_rise && !got_byte) begin
                        shreg_nx   = rx_byte;
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ptr_nx      = rx_byte[MEM_AW-1:0];
                            got_byte_nx = 1'b1;
                        end
                    end else if (scl_fall && got_byte) begin
                        got_byte_nx = 1'b0;
                        sda_oe_nx   = 1'b1;
                        state_nx    = WADDR_ACK;
                    end
                end
                WADDR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nx  = 1'b0;
                        bit_cnt_nx = 3'd0;
                        state_nx   = WDATA;
                    end
                end
                WDATA: begin
                    if (scl_rise && !got_byte) begin
                        shreg_nx   = rx_byte;
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            mem_we      = 1'b1;
                            wr_valid_nx = 1'b1;
                            wr_addr_nx  = ptr;
                            wr_data_nx  = rx_byte;
                            ptr_nx      = ptr + PTR_ONE;
                            got_byte_nx = 1'b1;
                        end
                    end else if (scl_fall && got_byte) begin
                        got_byte_nx = 1'b0;
                        sda_oe_nx   = 1'b1;
                        state_nx    = WDATA_ACK;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe_nx  = 1'b0;
                            bit_cnt_nx = 3'd0;
                            state_nx   = RD_MACK;
                        end else begin
                            bit_cnt_nx = bit_cnt + 3'd1;
                            rd_sh_nx   = {rd_sh[6:0], 1'b0};
                            sda_oe_nx  = ~rd_sh[6];
                        end
                    end
                end
                RD_MACK: begin
                    if (scl_rise && !got_byte) begin
                        ptr_nx = ptr + PTR_ONE;
                        if (!sda_s2) got_byte_nx = 1'b1;
                        else         state_nx    = IGNORE;
                    end else if (scl_fall && got_byte) begin
                        got_byte_nx = 1'b0;
                        rd_sh_nx    = mem_rd;
                        sda_oe_nx   = ~mem_rd[7];
                        bit_cnt_nx  = 3'd0;
                        state_nx    = RDATA;
                    end
                end
                IGNORE: ;
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: a bit-banged I2C master on an open-drain bus, a
// memory/pointer model updated per transaction, and a per-cycle monitor that
// matches write strobes against the model's expected commits.
module tb_i2c_target_mem;

    localparam logic [6:0] DEV = 7'h50;
    localparam int Q = 160;

    logic       aclk = 1'b0;
    logic       areset;
    logic       scl_m, sda_m;
    wire        sda_line;
    logic       sda_oe, busy, wr_valid;
    logic [7:0] wr_addr, wr_data, ptr;

    int tests = 0;
    int fails = 0;

    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr;
    logic [15:0] exp_q [$];
    logic [7:0]  rd_got [4];

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_mem #(.DEV_ADDR(DEV), .MEM_AW(8)) dut (
        .aclk(aclk), .areset(areset), .scl_i(scl_m), .sda_i(sda_line),
        .sda_oe(sda_oe), .busy(busy), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .ptr(ptr)
    );

    always #5 aclk = ~aclk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every write strobe must match the next expected commit, be one
    // cycle wide, and SDA drive may only move shortly after an SCL fall.
    logic prev_oe = 1'b0, prev_wv = 1'b0, prev_scl = 1'b1;
    int   since_fall = 100;
    always @(negedge aclk) begin
        logic [15:0] e;
        if (prev_scl && !scl_m) since_fall = 0;
        else if (since_fall < 100) since_fall++;
        if (!areset) begin
            if (wr_valid) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", {wr_addr, wr_data}, 16'hxxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e[15:8]);
                    check("wr_data", wr_data, e[7:0]);
                end
                if (prev_wv) check("wr_pulse_width", 2, 1);
            end
            if (sda_oe !== prev_oe)
                check("oe_edge_timing", (!scl_m && since_fall <= 3), 1);
        end
        prev_oe  = sda_oe;
        prev_wv  = wr_valid;
        prev_scl = scl_m;
    end

    task automatic bus_bit(input logic b, output logic seen);
        sda_m = b; #Q;
        scl_m = 1'b1; #Q;
        seen = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(~mack, s);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #(4*Q);
    endtask

    task automatic txn_write(input logic [7:0] addr, input int n,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] d [3];
        logic ack;
        d[0] = b0; d[1] = b1; d[2] = b2;
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        check("wr_dev_ack", ack, 1);
        check("wr_busy_after_match", busy, 1);
        send_byte(addr, ack);
        check("wr_waddr_ack", ack, 1);
        model_ptr = addr;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({model_ptr, d[i]});
            model_mem[model_ptr] = d[i];
            model_ptr = model_ptr + 8'd1;
            send_byte(d[i], ack);
            check("wr_data_ack", ack, 1);
        end
        bus_stop();
        check("wr_ptr", ptr, model_ptr);
        check("wr_busy_after_stop", busy, 0);
        check("wr_all_commits_seen", exp_q.size(), 0);
    endtask

    task automatic txn_read(input logic [7:0] addr, input int n);
        logic ack;
        logic [7:0] d;
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        check("rd_dev_w_ack", ack, 1);
        send_byte(addr, ack);
        check("rd_waddr_ack", ack, 1);
        model_ptr = addr;
        bus_start();
        send_byte({DEV, 1'b1}, ack);
        check("rd_dev_r_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, d);
            check("rd_data", d, model_mem[model_ptr]);
            rd_got[i] = d;
            model_ptr = model_ptr + 8'd1;
        end
        bus_stop();
        check("rd_ptr", ptr, model_ptr);
        check("rd_busy_after_stop", busy, 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout want finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic ack, s;
        areset = 1'b1;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        model_ptr = 8'd0;
        #102;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_ptr", ptr, 0);
        areset = 1'b0;
        #(4*Q);

        // Sequential write of three bytes at 0x10.
        txn_write(8'h10, 3, 8'h11, 8'h22, 8'h33);
        check("lit_write_ptr", ptr, 8'h13);

        // Random read back of the same three bytes.
        txn_read(8'h10, 3);
        check("lit_rd0", rd_got[0], 8'h11);
        check("lit_rd1", rd_got[1], 8'h22);
        check("lit_rd2", rd_got[2], 8'h33);
        check("lit_read_ptr", ptr, 8'h13);

        // Address mismatch: no ACK, no busy, no commits.
        bus_start();
        send_byte(8'hA2, ack);
        check("nomatch_nack", ack, 0);
        check("nomatch_busy", busy, 0);
        send_byte(8'h55, ack);
        check("nomatch_data_nack", ack, 0);
        bus_stop();
        check("nomatch_busy_after", busy, 0);
        check("nomatch_ptr", ptr, 8'h13);

        // Pointer wrap across the top of memory.
        txn_write(8'hFF, 2, 8'hAA, 8'hBB, 8'h00);
        check("lit_wrap_wr_ptr", ptr, 8'h01);
        txn_read(8'hFF, 2);
        check("lit_wrap_rd0", rd_got[0], 8'hAA);
        check("lit_wrap_rd1", rd_got[1], 8'hBB);
        check("lit_wrap_rd_ptr", ptr, 8'h01);

        // STOP after four bits of a data byte discards the partial byte.
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        check("abort_dev_ack", ack, 1);
        send_byte(8'h40, ack);
        check("abort_waddr_ack", ack, 1);
        model_ptr = 8'h40;
        bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
        bus_stop();
        check("abort_sda_oe", sda_oe, 0);
        check("abort_busy", busy, 0);
        check("abort_ptr", ptr, model_ptr);
        txn_write(8'h40, 1, 8'h5A, 8'h00, 8'h00);
        txn_read(8'h40, 1);
        check("lit_abort_rd", rd_got[0], 8'h5A);

        // Reset while the target drives a zero data bit.
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        send_byte(8'h10, ack);
        bus_start();
        send_byte({DEV, 1'b1}, ack);
        check("rstmid_dev_ack", ack, 1);
        check("rstmid_driving", sda_oe, 1);
        check("rstmid_busy", busy, 1);
        #4;
        areset = 1'b1;
        #1;
        check("rstmid_sda_oe", sda_oe, 0);
        check("rstmid_ptr", ptr, 0);
        check("rstmid_busy_clr", busy, 0);
        #45;
        areset = 1'b0;
        model_ptr = 8'd0;
        exp_q.delete();
        #(2*Q);
        bus_stop();
        txn_write(8'h20, 2, 8'hC3, 8'h3C, 8'h00);
        txn_read(8'h20, 2);
        check("lit_post_rst_rd0", rd_got[0], 8'hC3);
        check("lit_post_rst_rd1", rd_got[1], 8'h3C);
        check("lit_post_rst_ptr", ptr, 8'h22);

        #(4*Q);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
